// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for Mem_dados (clock/reset, req_* CPU request, resp_* response, mem_* memory port); sub-word stores via read-modify-write
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           mem_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_we,
  input  logic [31:0]           mem_q
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_l, addr_sel, word_idx;
  logic [1:0] size_l;
  logic uns_l, we_l, live_err, sx;
  logic [31:0] wdata_l, merged, mask, merge_word, load_ext;
  logic [15:0] lane;
  logic [4:0] sh;
  function automatic logic bad_req(input logic [1:0] s, input logic [1:0] a);
    return s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a != 2'b00);
  endfunction
  assign req_ready = state == IDLE;
  assign live_err = bad_req(req_size, req_addr[1:0]);
  assign mem_we = !reset && (state == WRITE ||
                  (state == IDLE && req_valid && req_we && req_size == 2'b10 && !live_err));
  assign addr_sel = state == IDLE ? req_addr : addr_l;
  assign word_idx = {2'b0, addr_sel[ADDR_WIDTH-1:2]};
  assign mem_read_addr = word_idx;
  assign mem_write_addr = word_idx;
  assign mem_data = state == IDLE ? req_wdata : merged;
  assign sh = {addr_l[1:0], 3'b000};
  assign lane = 16'(mem_q >> sh);
  assign mask = (size_l == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign merge_word = (mem_q & ~mask) | ((wdata_l << sh) & mask);
  assign sx = size_l == 2'b00 ? !uns_l && lane[7] : !uns_l && lane[15];
  assign load_ext = size_l == 2'b00 ? {{24{sx}}, lane[7:0]} :
                    size_l == 2'b01 ? {{16{sx}}, lane} : mem_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      addr_l <= '0;
      size_l <= '0;
      uns_l <= 1'b0;
      we_l <= 1'b0;
      wdata_l <= '0;
      merged <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr_l <= req_addr;
          size_l <= req_size;
          uns_l <= req_unsigned;
          we_l <= req_we;
          wdata_l <= req_wdata;
          if (live_err) begin
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
          end else if (req_we && req_size == 2'b10) resp_valid <= 1'b1;
          else state <= READ;
        end
        READ: if (we_l) begin
          merged <= merge_word;
          state <= WRITE;
        end else begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
          state <= IDLE;
        end
        WRITE: begin
          resp_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
